// File: rtl/clock_disp_pkg.sv
// clock_disp_pkg: shared types and constants for the clock display scan path
package clock_disp_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  typedef logic [3:0] bcd_t;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic DP_OFF = 1'b1;
endpackage

// File: rtl/digit_scan_ctrl_scan_timer.sv
// scan_timer: slot, digit and frame counters for the display scan
module scan_timer #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_FRAMES = 100,
  parameter int SW = $clog2(SCAN_DIV),
  parameter int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
  parameter int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic [SW-1:0] slot_cnt,
  output logic [DW-1:0] idx_nxt,
  output logic slot_start,
  output logic slot_end,
  output logic frame_end,
  output logic blink_wrap
);
  logic [DW-1:0] dig_idx;
  logic [FW-1:0] frame_cnt;
  always_comb begin
    slot_start = run && slot_cnt == '0;
    slot_end = run && slot_cnt == SW'(SCAN_DIV - 1);
    frame_end = slot_end && dig_idx == DW'(NUM_DIGITS - 1);
    blink_wrap = frame_end && frame_cnt == FW'(BLINK_FRAMES - 1);
    idx_nxt = !run ? '0 : frame_end ? '0 : slot_end ? dig_idx + 1'b1 : dig_idx;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slot_cnt <= '0;
      dig_idx <= '0;
      frame_cnt <= '0;
    end else begin
      slot_cnt <= (!run || slot_end) ? '0 : slot_cnt + 1'b1;
      dig_idx <= idx_nxt;
      frame_cnt <= !run ? '0 : blink_wrap ? '0 : frame_end ? frame_cnt + 1'b1 : frame_cnt;
    end
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed 7-segment scan with blanking, frame snapshot and blink
module digit_scan_ctrl
  import clock_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [3:0] bcd_out,
  output logic [NUM_DIGITS-1:0] an,
  output logic dp,
  output logic frame_tick
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_LAST = BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0;
  localparam state_t START = BLANK_CYCLES > 0 ? BLANK : SHOW;
  state_t state, ns;
  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] idx_n;
  logic slot_start, slot_end, frame_end, blink_wrap, run, cap, phase, phase_d, show;
  logic [4*NUM_DIGITS-1:0] snap_dig, dig_d;
  logic [NUM_DIGITS-1:0] snap_dp, dp_d, snap_blk, blk_d, an_d;
  bcd_t bcd_d;
  logic dpo_d;
  assign run = enable && state != IDLE;
  scan_timer #(
    .NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk(clk), .rst(rst), .run(run), .slot_cnt(slot_cnt), .idx_nxt(idx_n),
    .slot_start(slot_start), .slot_end(slot_end), .frame_end(frame_end), .blink_wrap(blink_wrap)
  );
  // Outputs are computed from next-cycle values so the registered outputs line up with state.
  always_comb begin
    ns = !enable ? IDLE
       : (state == IDLE || slot_end) ? START
       : (state == BLANK && slot_cnt == SW'(BLK_LAST)) ? SHOW : state;
    cap = enable && (state == IDLE || frame_end);
    dig_d = !enable ? '0 : cap ? digits : snap_dig;
    dp_d = !enable ? '0 : cap ? dp_mask : snap_dp;
    blk_d = !enable ? '0 : cap ? blink_mask : snap_blk;
    phase_d = enable && (phase ^ blink_wrap);
    show = ns == SHOW && !(blk_d[idx_n] && phase_d);
    bcd_d = ns == IDLE ? '0 : dig_d[4*idx_n +: 4];
    an_d = show ? ~(NUM_DIGITS'(1) << idx_n) : AN_OFF[NUM_DIGITS-1:0];
    dpo_d = show ? ~dp_d[idx_n] : DP_OFF;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      snap_dig <= '0;
      snap_dp <= '0;
      snap_blk <= '0;
      phase <= 1'b0;
      bcd_out <= '0;
      an <= AN_OFF[NUM_DIGITS-1:0];
      dp <= DP_OFF;
      frame_tick <= 1'b0;
    end else begin
      state <= ns;
      snap_dig <= dig_d;
      snap_dp <= dp_d;
      snap_blk <= blk_d;
      phase <= phase_d;
      bcd_out <= bcd_d;
      an <= an_d;
      dp <= dpo_d;
      frame_tick <= frame_end;
    end
endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for the clock's multi-digit 7-segment display.
- Each scan slot selects one digit of a BCD display word and presents its BCD nibble on bcd_out for the downstream BCD-to-7-segment decoder.
- Drives the active-low digit enables and the decimal point.
- Adds anti-ghosting blanking, a per-frame input snapshot so counting never tears mid-frame, and per-digit blinking for time-set mode.

Parameters:
- NUM_DIGITS, 8, number of display digits (2..8).
- SCAN_DIV, 50000, clk cycles per digit slot (>= 2).
- BLANK_CYCLES, 1000, cycles at slot start with all digits off (0 .. SCAN_DIV-1; 0 = no blanking).
- BLINK_FRAMES, 100, full frames per blink half-period (>= 1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  scan enable; low = display dark, counters cleared
- digits  in  4*NUM_DIGITS  BCD word; digit i = digits[4i+3:4i], digit 0 rightmost
- dp_mask  in  NUM_DIGITS  1 = decimal point lit on digit i
- blink_mask  in  NUM_DIGITS  1 = digit i blinks
- bcd_out  out  4  BCD of the currently selected digit, to the decoder
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-low when showing
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse at the end of every full frame

Behaviour:
- Reset (async, rst=1): state IDLE; slot_cnt=0, dig_idx=0, frame_cnt=0, blink_phase=0 (visible); an all 1s, dp=1, bcd_out=0, frame_tick=0; snapshot registers cleared.
- State IDLE:
  - Outputs held at reset values.
  - On enable=1: go to BLANK with dig_idx=0 and slot_cnt=0.
  - In the same cycle, capture digits, dp_mask and blink_mask into snapshot registers.
- State BLANK:
  - an all 1s; dp=1; bcd_out = snapshot nibble of dig_idx.
  - Leave for SHOW when slot_cnt == BLANK_CYCLES-1.
  - If BLANK_CYCLES=0, BLANK is never entered; slot start goes straight to SHOW.
- State SHOW:
  - an[dig_idx]=0, all other bits 1.
  - If snapshot blink bit is set and blink_phase=1, an stays all 1s.
  - dp = ~snapshot dp bit, also forced to 1 when an is all 1s.
- Slot end (slot_cnt == SCAN_DIV-1):
  - slot_cnt returns to 0 and dig_idx increments.
  - If dig_idx == NUM_DIGITS-1, dig_idx wraps to 0 instead. In that case:
    - frame_tick=1 for exactly that cycle.
    - A new snapshot is captured in the same cycle.
    - frame_cnt increments; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - Next state is BLANK (or SHOW if BLANK_CYCLES=0).
- Latency: all outputs are registered. bcd_out changes on the first cycle of a slot, at least BLANK_CYCLES before any an bit goes low, giving the decoder settling time.
- enable falling, at any point: next cycle returns to IDLE with all counters, blink_phase and outputs at reset values. Re-enable restarts from digit 0 with visible blink phase.
- digits changing mid-frame: no effect until the next frame snapshot.
- Nibbles > 9 are passed through unchanged; the decoder defines their glyph.
- rst asserted mid-slot: immediate return to reset values; no partial frame_tick.
- Widths: slot_cnt = $clog2(SCAN_DIV), dig_idx = $clog2(NUM_DIGITS) (min 1), frame_cnt = $clog2(BLINK_FRAMES) (min 1). All compares are unsigned with no overflow.

Decomposition:
- Shared package clock_disp_pkg holds:
  - state enum {IDLE, BLANK, SHOW}
  - constants AN_OFF (all 1s) and DP_OFF (1'b1)
  - BCD nibble typedef
- One natural sub-module: scan_timer. It holds slot_cnt, dig_idx and frame_cnt, and emits slot_start, slot_end and frame_end strobes.
- The FSM, snapshot, blink and output logic stay in the top module.
- The decoder is instantiated by the parent, not inside this block.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
1. Reset then enable=1, digits=16'h1234 -> slots show bcd_out 4,3,2,1. an=1110,1101,1011,0111, each low for 6 cycles after 2 all-1s cycles. frame_tick pulses every 32 cycles.
2. Change digits to 16'h5678 at cycle 10 of a frame -> remainder of the frame still shows 1234; next frame shows 8,7,6,5.
3. blink_mask=4'b0011 -> digits 0-1 lit in frames 0-1, dark in frames 2-3 (an stays 1111 in their SHOW windows). Digits 2-3 are always lit.
4. dp_mask=4'b0100 -> dp=0 only during digit 2's SHOW cycles; dp=1 during all BLANK cycles.
5. enable dropped mid-SHOW of digit 2 -> next cycle an=1111, bcd_out=0, frame_tick=0. Re-enable starts at digit 0 with blink visible.
6. rst pulsed asynchronously between clk edges during SHOW -> an=1111, dp=1, bcd_out=0 immediately, without waiting for a clock edge. No frame_tick is emitted.
